// File: rtl/bundle_issue.sv
// -----------------------------------------------------------------------------
// bundle_issue
//
// Single-entry issue stage for a 4-lane instruction bundle. One bundle is
// captured from the fetch side into a hold register. It is released downstream
// once no lane reads or writes a register or predicate that the scoreboard
// still marks as pending, and once the downstream stage is ready. A flush
// discards the held bundle.
//
// Optional feature: define BUNDLE_ISSUE_STALL_CNT_EN to build a saturating
// counter of hazard-stall cycles on d2_stall_cnt. When the macro is not
// defined, d2_stall_cnt is tied to zero and no counter flops are built.
//
// Ports
//   clkrst_core_clk        in   core clock; all state changes on the rising edge
//   clkrst_core_rst_n      in   synchronous active-low reset
//   f2d_valid              in   fetch presents a bundle
//   d2f_ready              out  this block accepts the bundle this cycle
//   f2d_rs_num/rt_num/rd_num in [19:0]  lane i register numbers in [5i+4:5i]
//   f2d_rs_use/rt_use      in  [3:0]  lane i source register is read
//   f2d_rd_we/pred_we      in  [3:0]  lane i writes a register / predicate
//   f2d_pred_num           in  [7:0]  lane i guard predicate in [2i+1:2i]; 3 = none
//   sb2d_reg_scoreboard    in  [31:0] register has a write pending
//   sb2d_pred_scoreboard   in  [2:0]  predicate has a write pending
//   d2_flush               in   drop the held bundle; no issue, no accept
//   pc2d_ready             in   downstream can take a bundle
//   d2pc_out_valid         out  held bundle issues this cycle
//   d2pc_out_rd_num0..3    out  held destination number per lane
//   d2pc_out_rd_we0..3     out  lane writes rd (only while issuing)
//   d2pc_out_pred_we0..3   out  lane writes predicate rd_num[1:0] (only while issuing)
//   d2_stall_cnt           out  hazard-stall cycle count (see macro above)
// -----------------------------------------------------------------------------
module bundle_issue #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clkrst_core_clk,
  input  logic                   clkrst_core_rst_n,
  input  logic                   f2d_valid,
  output logic                   d2f_ready,
  input  logic [19:0]            f2d_rs_num,
  input  logic [19:0]            f2d_rt_num,
  input  logic [19:0]            f2d_rd_num,
  input  logic [3:0]             f2d_rs_use,
  input  logic [3:0]             f2d_rt_use,
  input  logic [3:0]             f2d_rd_we,
  input  logic [3:0]             f2d_pred_we,
  input  logic [7:0]             f2d_pred_num,
  input  logic [31:0]            sb2d_reg_scoreboard,
  input  logic [2:0]             sb2d_pred_scoreboard,
  input  logic                   d2_flush,
  input  logic                   pc2d_ready,
  output logic                   d2pc_out_valid,
  output logic [4:0]             d2pc_out_rd_num0,
  output logic [4:0]             d2pc_out_rd_num1,
  output logic [4:0]             d2pc_out_rd_num2,
  output logic [4:0]             d2pc_out_rd_num3,
  output logic                   d2pc_out_rd_we0,
  output logic                   d2pc_out_rd_we1,
  output logic                   d2pc_out_rd_we2,
  output logic                   d2pc_out_rd_we3,
  output logic                   d2pc_out_pred_we0,
  output logic                   d2pc_out_pred_we1,
  output logic                   d2pc_out_pred_we2,
  output logic                   d2pc_out_pred_we3,
  output logic [STALL_CNT_W-1:0] d2_stall_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e      state_q, state_d;

  // Hold register
  logic [19:0] rs_num_q, rt_num_q, rd_num_q;
  logic [3:0]  rs_use_q, rt_use_q, rd_we_q, pred_we_q;
  logic [7:0]  pred_num_q;

  logic [3:0]  lane_hazard;
  logic        hazard;
  logic        accept;
  logic [3:0]  sb_pred_ext;

  // Predicate 3 has no scoreboard bit; padding lets a 2-bit index address
  // the vector safely (index 3 is always masked off by the !=3 guards).
  assign sb_pred_ext = {1'b0, sb2d_pred_scoreboard};

  // ---------------------------------------------------------------------------
  // Per-lane hazard detection against the held bundle
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [4:0] rs_l, rt_l, rd_l;
    logic [1:0] pn_l;
    logic [1:0] pw_l;

    assign rs_l = rs_num_q[5*gi +: 5];
    assign rt_l = rt_num_q[5*gi +: 5];
    assign rd_l = rd_num_q[5*gi +: 5];
    assign pn_l = pred_num_q[2*gi +: 2];
    assign pw_l = rd_l[1:0];

    assign lane_hazard[gi] =
        (rs_use_q[gi]  & sb2d_reg_scoreboard[rs_l])
      | (rt_use_q[gi]  & sb2d_reg_scoreboard[rt_l])
      | (rd_we_q[gi]   & sb2d_reg_scoreboard[rd_l])
      | ((pn_l != 2'd3) & sb_pred_ext[pn_l])
      | (pred_we_q[gi] & (pw_l != 2'd3) & sb_pred_ext[pw_l]);
  end

  assign hazard = |lane_hazard;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clkrst_core_clk) begin
    if (!clkrst_core_rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. Flush has priority; an accept (possibly alongside an
  // issue) refills the entry; an issue alone drains it.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (d2_flush) begin
      state_d = EMPTY;
    end else if (accept) begin
      state_d = FULL;
    end else if (d2pc_out_valid) begin
      state_d = EMPTY;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Reset and flush both force handshakes low combinationally,
  // so a bundle held mid-stall cannot leak out while reset is asserted.
  // ---------------------------------------------------------------------------
  always_comb begin
    d2pc_out_valid = 1'b0;
    d2f_ready      = 1'b0;
    if (clkrst_core_rst_n && !d2_flush) begin
      d2pc_out_valid = (state_q == FULL) && !hazard && pc2d_ready;
      d2f_ready      = (state_q == EMPTY) || d2pc_out_valid;
    end
  end

  assign accept = f2d_valid & d2f_ready;

  // ---------------------------------------------------------------------------
  // Hold register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clkrst_core_clk) begin
    if (!clkrst_core_rst_n) begin
      rs_num_q   <= '0;
      rt_num_q   <= '0;
      rd_num_q   <= '0;
      rs_use_q   <= '0;
      rt_use_q   <= '0;
      rd_we_q    <= '0;
      pred_we_q  <= '0;
      pred_num_q <= '0;
    end else if (accept) begin
      rs_num_q   <= f2d_rs_num;
      rt_num_q   <= f2d_rt_num;
      rd_num_q   <= f2d_rd_num;
      rs_use_q   <= f2d_rs_use;
      rt_use_q   <= f2d_rt_use;
      rd_we_q    <= f2d_rd_we;
      pred_we_q  <= f2d_pred_we;
      pred_num_q <= f2d_pred_num;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue outputs: destination numbers always reflect the hold register,
  // write enables only while the bundle actually issues.
  // ---------------------------------------------------------------------------
  assign d2pc_out_rd_num0  = rd_num_q[4:0];
  assign d2pc_out_rd_num1  = rd_num_q[9:5];
  assign d2pc_out_rd_num2  = rd_num_q[14:10];
  assign d2pc_out_rd_num3  = rd_num_q[19:15];

  assign d2pc_out_rd_we0   = rd_we_q[0] & d2pc_out_valid;
  assign d2pc_out_rd_we1   = rd_we_q[1] & d2pc_out_valid;
  assign d2pc_out_rd_we2   = rd_we_q[2] & d2pc_out_valid;
  assign d2pc_out_rd_we3   = rd_we_q[3] & d2pc_out_valid;

  assign d2pc_out_pred_we0 = pred_we_q[0] & d2pc_out_valid;
  assign d2pc_out_pred_we1 = pred_we_q[1] & d2pc_out_valid;
  assign d2pc_out_pred_we2 = pred_we_q[2] & d2pc_out_valid;
  assign d2pc_out_pred_we3 = pred_we_q[3] & d2pc_out_valid;

  // ---------------------------------------------------------------------------
  // Optional hazard-stall counter (saturating). Cycles held only because
  // downstream is not ready are not counted.
  // ---------------------------------------------------------------------------
`ifdef BUNDLE_ISSUE_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == FULL) && hazard && !d2_flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clkrst_core_clk) begin
    if (!clkrst_core_rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign d2_stall_cnt = stall_cnt_q;
`else
  assign d2_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_bundle_issue.sv
// -----------------------------------------------------------------------------
// tb_bundle_issue
//
// Self-checking bench for bundle_issue. Each accepted bundle pushes its
// expected issue record to a scoreboard queue; each cycle with
// d2pc_out_valid pops and compares. Handshake expectations come from the
// scenario itself. Builds with or without BUNDLE_ISSUE_STALL_CNT_EN.
// -----------------------------------------------------------------------------
module tb_bundle_issue;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          f2d_valid;
  logic          d2f_ready;
  logic [19:0]   f2d_rs_num, f2d_rt_num, f2d_rd_num;
  logic [3:0]    f2d_rs_use, f2d_rt_use, f2d_rd_we, f2d_pred_we;
  logic [7:0]    f2d_pred_num;
  logic [31:0]   sb_reg;
  logic [2:0]    sb_pred;
  logic          d2_flush;
  logic          pc2d_ready;
  logic          d2pc_out_valid;
  logic [4:0]    rd0, rd1, rd2, rd3;
  logic          we0, we1, we2, we3;
  logic          pwe0, pwe1, pwe2, pwe3;
  logic [CW-1:0] d2_stall_cnt;

  always #5 clk = ~clk;

  bundle_issue #(.STALL_CNT_W(CW)) dut (
    .clkrst_core_clk      (clk),
    .clkrst_core_rst_n    (rst_n),
    .f2d_valid            (f2d_valid),
    .d2f_ready            (d2f_ready),
    .f2d_rs_num           (f2d_rs_num),
    .f2d_rt_num           (f2d_rt_num),
    .f2d_rd_num           (f2d_rd_num),
    .f2d_rs_use           (f2d_rs_use),
    .f2d_rt_use           (f2d_rt_use),
    .f2d_rd_we            (f2d_rd_we),
    .f2d_pred_we          (f2d_pred_we),
    .f2d_pred_num         (f2d_pred_num),
    .sb2d_reg_scoreboard  (sb_reg),
    .sb2d_pred_scoreboard (sb_pred),
    .d2_flush             (d2_flush),
    .pc2d_ready           (pc2d_ready),
    .d2pc_out_valid       (d2pc_out_valid),
    .d2pc_out_rd_num0     (rd0),
    .d2pc_out_rd_num1     (rd1),
    .d2pc_out_rd_num2     (rd2),
    .d2pc_out_rd_num3     (rd3),
    .d2pc_out_rd_we0      (we0),
    .d2pc_out_rd_we1      (we1),
    .d2pc_out_rd_we2      (we2),
    .d2pc_out_rd_we3      (we3),
    .d2pc_out_pred_we0    (pwe0),
    .d2pc_out_pred_we1    (pwe1),
    .d2pc_out_pred_we2    (pwe2),
    .d2pc_out_pred_we3    (pwe3),
    .d2_stall_cnt         (d2_stall_cnt)
  );

  typedef struct packed {
    logic [19:0] rs_num;
    logic [19:0] rt_num;
    logic [19:0] rd_num;
    logic [3:0]  rs_use;
    logic [3:0]  rt_use;
    logic [3:0]  rd_we;
    logic [3:0]  pred_we;
    logic [7:0]  pred_num;
  } bundle_t;

  typedef struct packed {
    logic [19:0] rd_num;
    logic [3:0]  rd_we;
    logic [3:0]  pred_we;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   exp_stall = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef BUNDLE_ISSUE_STALL_CNT_EN
    return (exp_stall > 15) ? 32'd15 : 32'(exp_stall);
`else
    return 32'd0;
`endif
  endfunction

  function automatic bundle_t nop_bundle();
    bundle_t b;
    b          = '0;
    b.pred_num = 8'hFF;
    return b;
  endfunction

  task automatic drive(input logic v, input bundle_t b);
    f2d_valid    = v;
    f2d_rs_num   = b.rs_num;
    f2d_rt_num   = b.rt_num;
    f2d_rd_num   = b.rd_num;
    f2d_rs_use   = b.rs_use;
    f2d_rt_use   = b.rt_use;
    f2d_rd_we    = b.rd_we;
    f2d_pred_we  = b.pred_we;
    f2d_pred_num = b.pred_num;
  endtask

  task automatic set_sb(input logic [31:0] r, input logic [2:0] p);
    sb_reg  = r;
    sb_pred = p;
  endtask

  // One clock cycle: check handshakes and issue data at the negedge, update
  // the scoreboard, then advance to just past the next rising edge.
  task automatic step(input string tag, input logic exp_valid, input logic exp_ready);
    exp_t e;
    @(negedge clk);
    check_val({tag, ":valid"}, 32'(d2pc_out_valid), 32'(exp_valid));
    check_val({tag, ":ready"}, 32'(d2f_ready), 32'(exp_ready));
    if (d2pc_out_valid) begin
      check_val({tag, ":sb_has_entry"}, 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_val({tag, ":rd_num"}, 32'({rd3, rd2, rd1, rd0}), 32'(e.rd_num));
        check_val({tag, ":rd_we"},  32'({we3, we2, we1, we0}), 32'(e.rd_we));
        check_val({tag, ":pred_we"}, 32'({pwe3, pwe2, pwe1, pwe0}), 32'(e.pred_we));
        $display("issue %s rd=%05h we=%h pwe=%h", tag, e.rd_num, e.rd_we, e.pred_we);
      end
    end else begin
      check_val({tag, ":we_idle"}, 32'({we3, we2, we1, we0, pwe3, pwe2, pwe1, pwe0}), 32'd0);
    end
    if (f2d_valid && exp_ready) begin
      sb_q.push_back({f2d_rd_num, f2d_rd_we, f2d_pred_we});
    end
    @(posedge clk);
    #1;
  endtask

  // Accept a bundle with a clear scoreboard, then present the given
  // scoreboard / downstream state and confirm stall-or-issue behaviour.
  task automatic hazard_case(input string tag, input bundle_t b, input logic [31:0] sreg,
                             input logic [2:0] spred, input logic stalls, input logic pcr);
    set_sb('0, '0);
    pc2d_ready = 1'b1;
    drive(1'b1, b);
    step({tag, ":acc"}, 1'b0, 1'b1);
    drive(1'b0, nop_bundle());
    set_sb(sreg, spred);
    pc2d_ready = pcr;
    step({tag, ":hold"}, !stalls && pcr, !stalls && pcr);
    if (stalls) exp_stall++;
    if (stalls || !pcr) begin
      set_sb('0, '0);
      pc2d_ready = 1'b1;
      step({tag, ":rel"}, 1'b1, 1'b1);
    end
    check_val({tag, ":cnt"}, 32'(d2_stall_cnt), exp_cnt());
  endtask

  bundle_t b;

  initial begin
    // ---------------- reset ----------------
    rst_n      = 1'b0;
    d2_flush   = 1'b0;
    pc2d_ready = 1'b1;
    set_sb('0, '0);
    drive(1'b0, nop_bundle());
    step("rst0", 1'b0, 1'b0);
    step("rst1", 1'b0, 1'b0);
    check_val("rst:rd_num", 32'({rd3, rd2, rd1, rd0}), 32'd0);
    check_val("rst:cnt", 32'(d2_stall_cnt), 32'd0);
    rst_n = 1'b1;
    step("idle", 1'b0, 1'b1);

    // ---------------- rs hazard held for three cycles ----------------
    b              = nop_bundle();
    b.rs_num[4:0]  = 5'd5;
    b.rs_use[0]    = 1'b1;
    b.rd_num       = 20'h1_2345;
    b.rd_we        = 4'b0101;
    drive(1'b1, b);
    step("rs3:acc", 1'b0, 1'b1);
    drive(1'b0, nop_bundle());
    set_sb(32'h0000_0020, 3'b000);
    for (int i = 0; i < 3; i++) step("rs3:stall", 1'b0, 1'b0);
    exp_stall += 3;
    set_sb('0, '0);
    step("rs3:issue", 1'b1, 1'b1);
    check_val("rs3:cnt", 32'(d2_stall_cnt), exp_cnt());
    step("rs3:empty", 1'b0, 1'b1);

    // ---------------- back-to-back, no hazards ----------------
    for (int i = 0; i < 4; i++) begin
      b = bundle_t'({$urandom, $urandom, $urandom});
      drive(1'b1, b);
      step("b2b", i != 0, 1'b1);
    end
    drive(1'b0, nop_bundle());
    step("b2b:last", 1'b1, 1'b1);
    step("b2b:empty", 1'b0, 1'b1);

    // ---------------- per-source hazard table ----------------
    b = nop_bundle(); b.rt_num[9:5] = 5'd9; b.rt_use[1] = 1'b1; b.rd_num = 20'hABCDE;
    hazard_case("rt1", b, 32'h0000_0200, 3'b000, 1'b1, 1'b1);
    b = nop_bundle(); b.rd_num[19:15] = 5'd31; b.rd_we[3] = 1'b1;
    hazard_case("rd3", b, 32'h8000_0000, 3'b000, 1'b1, 1'b1);
    b = nop_bundle(); b.rs_num[14:10] = 5'd7; b.rs_use[2] = 1'b1;
    hazard_case("rs2_other", b, 32'h0000_0040, 3'b000, 1'b0, 1'b1);
    b = nop_bundle(); b.rs_num = 20'h0_0005; b.rt_num = 20'hFFFFF;
    hazard_case("no_use", b, 32'hFFFF_FFFF, 3'b000, 1'b0, 1'b1);
    b = nop_bundle(); b.rd_num[9:5] = 5'd2; b.pred_we[1] = 1'b1;
    hazard_case("pwe1", b, 32'h0, 3'b100, 1'b1, 1'b1);
    b = nop_bundle(); b.rd_num[4:0] = 5'd3; b.pred_we[0] = 1'b1;
    hazard_case("pwe_p3", b, 32'h0, 3'b111, 1'b0, 1'b1);
    b = nop_bundle(); b.rd_num = 20'h55555;
    hazard_case("pc_busy", b, 32'h0, 3'b000, 1'b0, 1'b0);

    // ---------------- predicate read hazard, then unpredicated ----------------
    b = nop_bundle(); b.pred_num[5:4] = 2'd1; b.rd_num = 20'h0_1111;
    drive(1'b1, b);
    step("pred:acc", 1'b0, 1'b1);
    drive(1'b0, nop_bundle());
    set_sb('0, 3'b010);
    step("pred:stall0", 1'b0, 1'b0);
    step("pred:stall1", 1'b0, 1'b0);
    exp_stall += 2;
    b = nop_bundle(); b.rd_num = 20'h2_2222; b.rd_we = 4'b1000;
    set_sb('0, '0);
    drive(1'b1, b);
    step("pred:issue_acc", 1'b1, 1'b1);
    drive(1'b0, nop_bundle());
    set_sb('0, 3'b010);
    step("pred3:issue", 1'b1, 1'b1);
    set_sb('0, '0);
    check_val("pred:cnt", 32'(d2_stall_cnt), exp_cnt());

    // ---------------- flush while stalled ----------------
    b = nop_bundle(); b.rs_num[4:0] = 5'd12; b.rs_use[0] = 1'b1;
    drive(1'b1, b);
    step("fl:acc", 1'b0, 1'b1);
    drive(1'b0, nop_bundle());
    set_sb(32'h0000_1000, 3'b000);
    step("fl:stall", 1'b0, 1'b0);
    exp_stall++;
    d2_flush = 1'b1;
    b = nop_bundle(); b.rd_num = 20'h7_7777;
    drive(1'b1, b);
    step("fl:flush", 1'b0, 1'b0);
    sb_q.delete();
    d2_flush = 1'b0;
    drive(1'b0, nop_bundle());
    set_sb('0, '0);
    step("fl:empty", 1'b0, 1'b1);
    check_val("fl:cnt", 32'(d2_stall_cnt), exp_cnt());

    // ---------------- lane3 rd=31 single-cycle write enable ----------------
    b = nop_bundle(); b.rd_num[19:15] = 5'd31; b.rd_we[3] = 1'b1;
    drive(1'b1, b);
    step("rd31:acc", 1'b0, 1'b1);
    drive(1'b0, nop_bundle());
    step("rd31:issue", 1'b1, 1'b1);
    step("rd31:after", 1'b0, 1'b1);

    // ---------------- reset while stalled with saturated counter ----------------
    b = nop_bundle(); b.rs_num[4:0] = 5'd5; b.rs_use[0] = 1'b1; b.rd_num = 20'hFFFFF;
    b.rd_we = 4'hF;
    drive(1'b1, b);
    step("sat:acc", 1'b0, 1'b1);
    drive(1'b0, nop_bundle());
    set_sb(32'h0000_0020, 3'b000);
    for (int i = 0; i < 16; i++) step("sat:stall", 1'b0, 1'b0);
    exp_stall += 16;
    check_val("sat:cnt", 32'(d2_stall_cnt), exp_cnt());
    rst_n = 1'b0;
    step("sat:rst", 1'b0, 1'b0);
    exp_stall = 0;
    sb_q.delete();
    check_val("sat:rst_cnt", 32'(d2_stall_cnt), 32'd0);
    check_val("sat:rst_rd", 32'({rd3, rd2, rd1, rd0}), 32'd0);
    rst_n = 1'b1;
    set_sb('0, '0);
    step("sat:post_rst", 1'b0, 1'b1);
    check_val("end:sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
